// File: rtl/conversor_bcd.sv
// Sequential 44-bit binary to 14-digit packed BCD converter (double-dabble).
// Performs one shift-add-3 step per clock and uses a start/busy/done handshake.
module conversor_bcd (
    input  logic        clock,
    input  logic        reset,
    input  logic [43:0] Entrada,
    input  logic        inicio,
    output logic [55:0] Bcd,
    output logic        ocupado,
    output logic        pronto
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    localparam int unsigned NUM_DIGITOS = 14;
    localparam logic [5:0]  NUM_PASSOS  = 6'd44;

    estado_t     estado_q;
    logic [43:0] bin_q;
    logic [55:0] esc_q;
    logic [5:0]  cnt_q;
    logic [55:0] bcd_q;
    logic        ocupado_q;
    logic        pronto_q;

    // Scratch register after the per-digit add-3 correction; no carry crosses digits.
    logic [55:0] esc_d;

    always_comb begin
        // NOTE: default assignment first, so no path leaves esc_d unassigned (no latch).
        esc_d = esc_q;
        for (int k = 0; k < NUM_DIGITOS; k++) begin
            if (esc_q[4*k +: 4] >= 4'd5) begin
                esc_d[4*k +: 4] = esc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // update together from the values that held before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: every register, including the result, is cleared, so an aborted
            // conversion cannot leave a partial value on Bcd.
            estado_q  <= OCIOSO;
            bin_q     <= '0;
            esc_q     <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (inicio) begin
                        bin_q     <= Entrada;
                        esc_q     <= '0;
                        cnt_q     <= NUM_PASSOS;
                        ocupado_q <= 1'b1;
                        estado_q  <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    // Digit 13 never exceeds 1, so bit 55 of esc_d is always 0 and is safely dropped.
                    {esc_q, bin_q} <= {esc_d[54:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        estado_q <= FIM;
                    end
                end
                FIM: begin
                    bcd_q     <= esc_q;
                    pronto_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign Bcd     = bcd_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: directed handshake scenarios plus random
// values, all compared against a decimal-arithmetic reference model.
module tb_conversor_bcd;

    logic        clock = 1'b0;
    logic        reset;
    logic [43:0] Entrada;
    logic        inicio;
    logic [55:0] Bcd;
    logic        ocupado;
    logic        pronto;

    int n_cmp = 0;
    int n_mis = 0;
    int ciclo = 0;

    always #5 clock = ~clock;

    conversor_bcd dut (
        .clock   (clock),
        .reset   (reset),
        .Entrada (Entrada),
        .inicio  (inicio),
        .Bcd     (Bcd),
        .ocupado (ocupado),
        .pronto  (pronto)
    );

    // Reference: split the value into decimal digits with plain division.
    function automatic logic [55:0] ref_bcd(input logic [43:0] v);
        longint unsigned x = 64'(v);
        logic [55:0] r = '0;
        for (int k = 0; k < 14; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [43:0] rand44();
        logic [63:0] r = {$urandom(), $urandom()};
        return r[43:0] >> $urandom_range(0, 43);
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
        ciclo++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after the start edge; returns edges until pronto and busy cycles seen.
    task automatic wait_pronto(output int lat, output int busy);
        lat  = -1;
        busy = ocupado ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (pronto) begin
                lat = n;
                break;
            end
            if (ocupado) busy++;
        end
    endtask

    task automatic convert(input logic [43:0] v, input string tag);
        int lat, busy;
        Entrada = v;
        inicio  = 1'b1;
        tick();
        inicio  = 1'b0;
        Entrada = rand44();
        wait_pronto(lat, busy);
        check({tag, " latency"}, 64'(lat), 64'd45);
        check({tag, " ocupado cycles"}, 64'(busy), 64'd45);
        check({tag, " bcd"}, 64'(Bcd), 64'(ref_bcd(v)));
        check({tag, " ocupado at pronto"}, 64'(ocupado), 64'd0);
        tick();
        check({tag, " pronto one cycle"}, 64'(pronto), 64'd0);
        check({tag, " bcd held"}, 64'(Bcd), 64'(ref_bcd(v)));
    endtask

    initial begin
        int lat, busy, t1, t2, extra;

        // Reset with inicio high must not start anything.
        reset   = 1'b1;
        inicio  = 1'b1;
        Entrada = 44'd12345;
        tick();
        tick();
        check("reset bcd", 64'(Bcd), 64'd0);
        check("reset pronto", 64'(pronto), 64'd0);
        check("reset ocupado", 64'(ocupado), 64'd0);
        reset  = 1'b0;
        inicio = 1'b0;
        tick();
        check("post-reset idle", 64'(ocupado), 64'd0);

        convert(44'd0, "zero");
        convert(44'd28, "small28");
        convert(44'hFFF_FFFF_FFFF, "full scale");
        check("full scale literal", 64'(Bcd), 64'h0017_5921_8604_4415);

        // inicio and Entrada changes during a conversion are ignored.
        Entrada = 44'd12345;
        inicio  = 1'b1;
        tick();
        inicio  = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        Entrada = 44'd999;
        inicio  = 1'b1;
        tick();
        inicio  = 1'b0;
        lat = -1;
        for (int n = 11; n <= 100; n++) begin
            tick();
            if (pronto) begin
                lat = n;
                break;
            end
        end
        check("busy-ignore latency", 64'(lat), 64'd45);
        check("busy-ignore bcd", 64'(Bcd), 64'h12345);
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pronto) extra++;
        end
        check("busy-ignore no extra pronto", 64'(extra), 64'd0);

        // Back-to-back with inicio held high.
        Entrada = 44'd4;
        inicio  = 1'b1;
        tick();
        Entrada = 44'd12;
        wait_pronto(lat, busy);
        t1 = ciclo;
        check("b2b first latency", 64'(lat), 64'd45);
        check("b2b first bcd", 64'(Bcd), 64'h04);
        tick();
        inicio = 1'b0;
        check("b2b restart ocupado", 64'(ocupado), 64'd1);
        wait_pronto(lat, busy);
        t2 = ciclo;
        check("b2b pronto spacing", 64'(t2 - t1), 64'd46);
        check("b2b second bcd", 64'(Bcd), 64'h12);
        tick();

        // Reset in the middle of a conversion.
        Entrada = rand44();
        inicio  = 1'b1;
        tick();
        inicio  = 1'b0;
        for (int i = 1; i <= 19; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid-reset bcd", 64'(Bcd), 64'd0);
        check("mid-reset ocupado", 64'(ocupado), 64'd0);
        check("mid-reset pronto", 64'(pronto), 64'd0);
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pronto || ocupado) extra++;
        end
        check("mid-reset stays idle", 64'(extra), 64'd0);
        convert(44'd9999999999, "after reset");
        check("after reset literal", 64'(Bcd), 64'h0000_9999_9999_99);

        // Random values.
        for (int i = 0; i < 12; i++) begin
            convert(rand44(), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
